// File: rtl/sensor_link_ctrl_if.sv
// Signal bundle for sensor_link_ctrl: Nios II custom-instruction side, UART byte
// handshakes and the unsolicited-frame alarm output.
interface sensor_link_ctrl_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_done;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        alarm_valid;
  logic [7:0]  alarm_data;

  modport slave (
    input  clk_en, start, dataa, tx_done, rx_byte, rx_valid,
    output result, done, busy, tx_byte, tx_valid, alarm_valid, alarm_data
  );

  modport master (
    output clk_en, start, dataa, tx_done, rx_byte, rx_valid,
    input  result, done, busy, tx_byte, tx_valid, alarm_valid, alarm_data
  );
endinterface

// File: rtl/sensor_link_ctrl.sv
// Multicycle custom-instruction controller: sends a sensor address over UART, collects a
// {data, check} reply with retries, and reports unsolicited valid frames as alarms.
module sensor_link_ctrl #(
  parameter int         NUM_SENSORS    = 16,
  parameter int         TIMEOUT_CYCLES = 500000,
  parameter int         MAX_RETRIES    = 2,
  parameter logic [7:0] CHECKSUM_KEY   = 8'h37
) (
  input  logic              clk,
  input  logic              reset,
  sensor_link_ctrl_if.slave bus
);

  localparam int                 TIMER_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]         RETRY_LIMIT = 3'(MAX_RETRIES);
  localparam logic [8:0]         ADDR_LIMIT  = 9'(NUM_SENSORS);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_D,
    WAIT_C,
    VERIFY,
    RESPOND,
    A_CHK
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_CHKFAIL = 2'b10,
    ST_BADADDR = 2'b11
  } status_t;

  state_t             state;
  logic               pending;
  logic [7:0]         addr;
  logic [7:0]         data_byte;
  logic [7:0]         check_byte;
  logic [TIMER_W-1:0] timer;
  logic [2:0]         retry;

  logic [31:0]        result_q;
  logic               done_q;
  logic               busy_q;
  logic [7:0]         tx_byte_q;
  logic               tx_valid_q;
  logic               alarm_valid_q;
  logic [7:0]         alarm_data_q;

  logic               accept;
  logic               deadline;
  logic               check_ok;
  logic               alarm_ok;
  logic               fail_now;
  status_t            fail_status;
  logic [7:0]         fail_data;
  logic               unused_dataa_upper;

  assign accept             = bus.start && bus.clk_en && !pending && !busy_q;
  assign deadline           = (timer >= TIMER_LAST);
  assign check_ok           = (check_byte == (data_byte ^ CHECKSUM_KEY));
  assign alarm_ok           = (bus.rx_byte == (data_byte ^ CHECKSUM_KEY));
  assign unused_dataa_upper = ^bus.dataa[31:8];

  // A byte arriving on the deadline cycle beats the timeout.
  always_comb begin
    fail_now    = 1'b0;
    fail_status = ST_TIMEOUT;
    fail_data   = 8'h00;
    case (state)
      WAIT_D, WAIT_C: fail_now = !bus.rx_valid && deadline;
      VERIFY: begin
        if (!check_ok) begin
          fail_now    = 1'b1;
          fail_status = ST_CHKFAIL;
          fail_data   = data_byte;
        end
      end
      default: fail_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pending       <= 1'b0;
      addr          <= 8'h00;
      data_byte     <= 8'h00;
      check_byte    <= 8'h00;
      timer         <= '0;
      retry         <= 3'd0;
      result_q      <= 32'h0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      tx_byte_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      alarm_valid_q <= 1'b0;
      alarm_data_q  <= 8'h00;
    end else begin
      done_q        <= 1'b0;
      alarm_valid_q <= 1'b0;

      // Requests are latched in any state, so one arriving mid-alarm waits in pending.
      if (accept) begin
        pending <= 1'b1;
        addr    <= bus.dataa[7:0];
        busy_q  <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (pending) begin
            pending <= 1'b0;
            retry   <= 3'd0;
            if ({1'b0, addr} >= ADDR_LIMIT) begin
              state    <= RESPOND;
              done_q   <= 1'b1;
              result_q <= {14'b0, ST_BADADDR, addr, 8'h00};
            end else begin
              state      <= SEND;
              tx_valid_q <= 1'b1;
              tx_byte_q  <= addr;
            end
          end else if (bus.rx_valid) begin
            data_byte <= bus.rx_byte;
            timer     <= '0;
            state     <= A_CHK;
          end
        end

        SEND: begin
          if (bus.tx_done) begin
            tx_valid_q <= 1'b0;
            timer      <= '0;
            state      <= WAIT_D;
          end
        end

        WAIT_D: begin
          timer <= timer + 1'b1;
          if (bus.rx_valid) begin
            data_byte <= bus.rx_byte;
            state     <= WAIT_C;
          end
        end

        WAIT_C: begin
          timer <= timer + 1'b1;
          if (bus.rx_valid) begin
            check_byte <= bus.rx_byte;
            state      <= VERIFY;
          end
        end

        VERIFY: begin
          if (check_ok) begin
            state    <= RESPOND;
            done_q   <= 1'b1;
            result_q <= {14'b0, ST_OK, addr, data_byte};
          end
        end

        RESPOND: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        A_CHK: begin
          if (bus.rx_valid) begin
            if (alarm_ok) begin
              alarm_valid_q <= 1'b1;
              alarm_data_q  <= data_byte;
            end
            state <= IDLE;
          end else if (deadline) begin
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase

      // Failure handling overrides the per-state next state chosen above.
      if (fail_now) begin
        if (retry < RETRY_LIMIT) begin
          retry      <= retry + 3'd1;
          state      <= SEND;
          tx_valid_q <= 1'b1;
          tx_byte_q  <= addr;
        end else begin
          state    <= RESPOND;
          done_q   <= 1'b1;
          result_q <= {14'b0, fail_status, addr, fail_data};
        end
      end
    end
  end

  assign bus.result      = result_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.alarm_valid = alarm_valid_q;
  assign bus.alarm_data  = alarm_data_q;

endmodule

// File: tb/tb_sensor_link_ctrl.sv
// Directed bench for sensor_link_ctrl: a vector table of whole transactions plus
// hand-written sequences for latency, timeout edges, alarms and mid-transaction reset.
module tb_sensor_link_ctrl;

  localparam int NUM_VECS = 11;

  typedef struct packed {
    logic [31:0] dataa;
    logic [7:0]  tx_delay;
    logic [2:0]  reply_mask;
    logic [23:0] dbytes;
    logic [23:0] cbytes;
    logic [31:0] exp_result;
    logic [3:0]  exp_tx;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs [NUM_VECS];

  sensor_link_ctrl_if bus ();

  sensor_link_ctrl #(
    .NUM_SENSORS   (16),
    .TIMEOUT_CYCLES(100),
    .MAX_RETRIES   (2),
    .CHECKSUM_KEY  (8'h37)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic [31:0] dataa, input logic [7:0] dly,
                                 input logic [2:0] mask, input logic [23:0] d,
                                 input logic [23:0] c, input logic [31:0] res,
                                 input logic [3:0] ntx);
    vec_t v;
    v.dataa      = dataa;
    v.tx_delay   = dly;
    v.reply_mask = mask;
    v.dbytes     = d;
    v.cbytes     = c;
    v.exp_result = res;
    v.exp_tx     = ntx;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.tx_done  = 1'b0;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulseRx(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic startReq(input logic [31:0] a);
    @(negedge clk);
    bus.dataa  = a;
    bus.clk_en = 1'b1;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitTx(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.tx_valid) seen = 1'b1;
    end
  endtask

  task automatic waitDone(input int budget, output bit seen, output logic [31:0] res);
    seen = 1'b0;
    res  = '0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        res  = bus.result;
      end
    end
  endtask

  // Plays the UART side of one whole transaction and records what the DUT did.
  task automatic applyStimulus(input vec_t v, output logic [31:0] res, output int txs,
                               output int bad_bytes, output bit got_done);
    int attempt;
    int cyc;
    bit reply;
    res       = '0;
    txs       = 0;
    bad_bytes = 0;
    got_done  = 1'b0;
    attempt   = 0;
    cyc       = 0;
    startReq(v.dataa);
    while (!got_done && cyc < 1500 && txs < 6) begin
      if (bus.done) begin
        got_done = 1'b1;
        res      = bus.result;
      end else begin
        if (bus.tx_valid) begin
          txs++;
          if (bus.tx_byte != v.dataa[7:0]) bad_bytes++;
          repeat (int'(v.tx_delay)) @(negedge clk);
          bus.tx_done = 1'b1;
          @(negedge clk);
          bus.tx_done = 1'b0;
          reply = (attempt < 3) && 1'(v.reply_mask >> attempt);
          if (reply) begin
            repeat (2) @(negedge clk);
            pulseRx(8'(v.dbytes >> (8 * attempt)));
            pulseRx(8'(v.cbytes >> (8 * attempt)));
          end
          attempt++;
        end
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: actual=hung required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] res;
    int          txs;
    int          bad;
    bit          seen;
    int          extra;

    vecs[0]  = mkVec(32'h03, 8'd10, 3'b001, 24'h00002A, 24'h00001D, 32'h0000_032A, 4'd1);
    vecs[1]  = mkVec(32'h05, 8'd2,  3'b000, 24'h000000, 24'h000000, 32'h0001_0500, 4'd3);
    vecs[2]  = mkVec(32'h05, 8'd2,  3'b011, 24'h001010, 24'h002700, 32'h0000_0510, 4'd2);
    vecs[3]  = mkVec(32'h20, 8'd0,  3'b000, 24'h000000, 24'h000000, 32'h0003_2000, 4'd0);
    vecs[4]  = mkVec(32'h0F, 8'd1,  3'b001, 24'h0000FF, 24'h0000C8, 32'h0000_0FFF, 4'd1);
    vecs[5]  = mkVec(32'h10, 8'd0,  3'b000, 24'h000000, 24'h000000, 32'h0003_1000, 4'd0);
    vecs[6]  = mkVec(32'h07, 8'd3,  3'b111, 24'h444444, 24'h000000, 32'h0002_0744, 4'd3);
    vecs[7]  = mkVec(32'h09, 8'd0,  3'b010, 24'h008100, 24'h000000, 32'h0001_0900, 4'd3);
    vecs[8]  = mkVec(32'h00, 8'd4,  3'b001, 24'h00005A, 24'h00006D, 32'h0000_005A, 4'd1);
    vecs[9]  = mkVec(32'hABCD_EF02, 8'd5, 3'b001, 24'h000001, 24'h000036, 32'h0000_0201, 4'd1);
    vecs[10] = mkVec(32'hFF, 8'd0,  3'b000, 24'h000000, 24'h000000, 32'h0003_FF00, 4'd0);

    reset        = 1'b1;
    bus.clk_en   = 1'b0;
    bus.start    = 1'b0;
    bus.dataa    = 32'h0;
    bus.tx_done  = 1'b0;
    bus.rx_byte  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_result", bus.result, 32'h0);
    checkOutput("reset_ctrl", {28'h0, bus.done, bus.busy, bus.tx_valid, bus.alarm_valid}, 32'h0);
    checkOutput("reset_bytes", {16'h0, bus.tx_byte, bus.alarm_data}, 32'h0);
    reset = 1'b0;

    // start without clk_en must be ignored
    @(negedge clk);
    bus.dataa  = 32'h03;
    bus.clk_en = 1'b0;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.clk_en = 1'b1;
    checkOutput("clken_low_busy", 32'(bus.busy), 32'd0);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.tx_valid || bus.done || bus.busy) extra++;
    end
    checkOutput("clken_low_idle", 32'(extra), 32'd0);

    for (int i = 0; i < NUM_VECS; i++) begin
      doReset();
      applyStimulus(vecs[i], res, txs, bad, seen);
      checkOutput($sformatf("vec%0d_done", i), 32'(seen), 32'd1);
      checkOutput($sformatf("vec%0d_result", i), res, vecs[i].exp_result);
      checkOutput($sformatf("vec%0d_txcount", i), 32'(txs), 32'(vecs[i].exp_tx));
      checkOutput($sformatf("vec%0d_txbyte", i), 32'(bad), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_after", i), {30'h0, bus.done, bus.busy}, 32'd0);
      checkOutput($sformatf("vec%0d_held", i), bus.result, vecs[i].exp_result);
    end

    // Bad address: done on the third cycle counting the start cycle, no UART traffic
    doReset();
    startReq(32'h20);
    checkOutput("bad_busy_rise", 32'(bus.busy), 32'd1);
    checkOutput("bad_done_early", 32'(bus.done), 32'd0);
    @(negedge clk);
    checkOutput("bad_done_latency", 32'(bus.done), 32'd1);
    checkOutput("bad_result", bus.result, 32'h0003_2000);
    checkOutput("bad_no_tx", 32'(bus.tx_valid), 32'd0);
    @(negedge clk);
    checkOutput("bad_after", {30'h0, bus.done, bus.busy}, 32'd0);

    // OK path latency; a second start while busy must be dropped
    doReset();
    startReq(32'h03);
    waitTx(50, seen);
    checkOutput("ok_tx_seen", 32'(seen), 32'd1);
    bus.dataa = 32'h20;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    repeat (3) @(negedge clk);
    pulseRx(8'h2A);
    pulseRx(8'h1D);
    checkOutput("ok_done_early", 32'(bus.done), 32'd0);
    @(negedge clk);
    checkOutput("ok_done_latency", 32'(bus.done), 32'd1);
    checkOutput("ok_result", bus.result, 32'h0000_032A);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.tx_valid) extra++;
    end
    checkOutput("busy_start_ignored", 32'(extra), 32'd0);

    // Data byte on the very last timeout cycle wins
    doReset();
    startReq(32'h04);
    waitTx(50, seen);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    repeat (99) @(negedge clk);
    pulseRx(8'h3C);
    pulseRx(8'h0B);
    @(negedge clk);
    checkOutput("edge_byte_wins_done", 32'(bus.done), 32'd1);
    checkOutput("edge_byte_wins_result", bus.result, 32'h0000_043C);

    // One cycle later the timeout fires and the request is re-sent
    doReset();
    startReq(32'h06);
    waitTx(50, seen);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    repeat (99) @(negedge clk);
    checkOutput("late_no_retry_yet", 32'(bus.tx_valid), 32'd0);
    @(negedge clk);
    checkOutput("late_retry_sent", {23'h0, bus.tx_valid, bus.tx_byte}, 32'h0000_0106);

    // Unsolicited frames
    doReset();
    pulseRx(8'h55);
    pulseRx(8'h62);
    checkOutput("alarm_pulse", {23'h0, bus.alarm_valid, bus.alarm_data}, 32'h0000_0155);
    @(negedge clk);
    checkOutput("alarm_one_cycle", 32'(bus.alarm_valid), 32'd0);
    bus.rx_byte = 8'h11;
    pulseRx(8'h55);
    pulseRx(8'h00);
    extra = 0;
    repeat (4) begin
      if (bus.alarm_valid) extra++;
      @(negedge clk);
    end
    checkOutput("alarm_bad_dropped", 32'(extra), 32'd0);
    checkOutput("alarm_data_held", 32'(bus.alarm_data), 32'h55);
    pulseRx(8'hA0);
    repeat (110) @(negedge clk);
    pulseRx(8'h12);
    pulseRx(8'h25);
    checkOutput("alarm_after_timeout", {23'h0, bus.alarm_valid, bus.alarm_data}, 32'h0000_0112);

    // Request arriving during an alarm frame is served once the frame ends
    @(negedge clk);
    pulseRx(8'h55);
    bus.dataa  = 32'h20;
    bus.clk_en = 1'b1;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("achk_req_busy", {30'h0, bus.busy, bus.done}, 32'd2);
    pulseRx(8'h62);
    checkOutput("achk_alarm_first", {30'h0, bus.alarm_valid, bus.done}, 32'd2);
    waitDone(10, seen, res);
    checkOutput("achk_req_done", 32'(seen), 32'd1);
    checkOutput("achk_req_result", res, 32'h0003_2000);

    // Reset in WAIT_D aborts at once, then a fresh request completes
    startReq(32'h01);
    waitTx(50, seen);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_ctrl", {28'h0, bus.done, bus.busy, bus.tx_valid, bus.alarm_valid}, 32'h0);
    checkOutput("midreset_result", bus.result, 32'h0);
    checkOutput("midreset_bytes", {16'h0, bus.tx_byte, bus.alarm_data}, 32'h0);
    reset = 1'b0;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done || bus.tx_valid) extra++;
    end
    checkOutput("midreset_no_done", 32'(extra), 32'd0);
    applyStimulus(mkVec(32'h01, 8'd3, 3'b001, 24'h000011, 24'h000026, 32'h0000_0111, 4'd1),
                  res, txs, bad, seen);
    checkOutput("postreset_done", 32'(seen), 32'd1);
    checkOutput("postreset_result", res, 32'h0000_0111);
    checkOutput("postreset_txcount", 32'(txs), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
